// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sequencing read/write accesses onto a single-port memory.
// Each access takes three cycles: grant in IDLE, one ACCESS cycle with an enable, one ACK cycle.
module mem_arbiter #(
  parameter int ADDR_LEN = 8,
  parameter int WORD_LEN = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req0_i,
  input  logic                req1_i,
  input  logic                we0_i,
  input  logic                we1_i,
  input  logic [ADDR_LEN-1:0] addr0_i,
  input  logic [ADDR_LEN-1:0] addr1_i,
  input  logic [WORD_LEN-1:0] wdata0_i,
  input  logic [WORD_LEN-1:0] wdata1_i,
  output logic                ack0_o,
  output logic                ack1_o,
  output logic [WORD_LEN-1:0] rdata0_o,
  output logic [WORD_LEN-1:0] rdata1_o,
  output logic                busy_o,
  output logic [ADDR_LEN-1:0] mem_addr_o,
  output logic                mem_r_en_o,
  output logic                mem_w_en_o,
  output logic [WORD_LEN-1:0] mem_wdata_o,
  input  logic [WORD_LEN-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2
  } state_t;

  state_t              state_q;
  logic                owner_q;
  logic                last_gnt_q;
  logic                we_q;
  logic                ack0_q;
  logic                ack1_q;
  logic                busy_q;
  logic                mem_r_en_q;
  logic                mem_w_en_q;
  logic [ADDR_LEN-1:0] mem_addr_q;
  logic [WORD_LEN-1:0] mem_wdata_q;
  logic [WORD_LEN-1:0] rdata0_q;
  logic [WORD_LEN-1:0] rdata1_q;

  logic                gnt_d;
  logic                we_d;
  logic [ADDR_LEN-1:0] addr_d;
  logic [WORD_LEN-1:0] wdata_d;

  // On a tie the port that was not served last wins.
  always_comb begin
    gnt_d = 1'b0;
    if (req0_i && req1_i) begin
      gnt_d = ~last_gnt_q;
    end else if (req1_i) begin
      gnt_d = 1'b1;
    end
    we_d    = gnt_d ? we1_i    : we0_i;
    addr_d  = gnt_d ? addr1_i  : addr0_i;
    wdata_d = gnt_d ? wdata1_i : wdata0_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      last_gnt_q  <= 1'b1;
      we_q        <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      busy_q      <= 1'b0;
      mem_r_en_q  <= 1'b0;
      mem_w_en_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req0_i || req1_i) begin
            owner_q     <= gnt_d;
            we_q        <= we_d;
            mem_addr_q  <= addr_d;
            mem_wdata_q <= wdata_d;
            mem_w_en_q  <= we_d;
            mem_r_en_q  <= ~we_d;
            busy_q      <= 1'b1;
            state_q     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!we_q) begin
            if (owner_q) rdata1_q <= mem_rdata_i;
            else         rdata0_q <= mem_rdata_i;
          end
          mem_r_en_q <= 1'b0;
          mem_w_en_q <= 1'b0;
          ack0_q     <= ~owner_q;
          ack1_q     <= owner_q;
          state_q    <= S_ACK;
        end
        S_ACK: begin
          ack0_q     <= 1'b0;
          ack1_q     <= 1'b0;
          last_gnt_q <= owner_q;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack0_o      = ack0_q;
  assign ack1_o      = ack1_q;
  assign rdata0_o    = rdata0_q;
  assign rdata1_o    = rdata1_q;
  assign busy_o      = busy_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_r_en_o  = mem_r_en_q;
  assign mem_w_en_o  = mem_w_en_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_arbiter;
  logic       clk_i, rst_i;
  logic       req0_i, req1_i, we0_i, we1_i;
  logic [7:0] addr0_i, addr1_i, wdata0_i, wdata1_i;
  logic       ack0_o, ack1_o, busy_o, mem_r_en_o, mem_w_en_o;
  logic [7:0] rdata0_o, rdata1_o, mem_addr_o, mem_wdata_o, mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_LEN(8), .WORD_LEN(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_i(req0_i), .req1_i(req1_i), .we0_i(we0_i), .we1_i(we1_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
    .ack0_o(ack0_o), .ack1_o(ack1_o), .rdata0_o(rdata0_o), .rdata1_o(rdata1_o),
    .busy_o(busy_o), .mem_addr_o(mem_addr_o), .mem_r_en_o(mem_r_en_o),
    .mem_w_en_o(mem_w_en_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Memory stand-in: combinational read, level-sensitive write.
  logic [7:0] mem [0:255];
  assign mem_rdata = mem[mem_addr_o];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    forever begin
      @(mem_w_en_o or mem_addr_o or mem_wdata_o);
      if (mem_w_en_o) mem[mem_addr_o] = mem_wdata_o;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one transaction in flight, counted down in cycles until done.
  logic [7:0] ref_mem [logic [7:0]];
  int         m_left;
  bit         m_port, m_we, m_last;
  logic [7:0] m_addr, m_wdata, m_result, m_rdata0, m_rdata1;

  function automatic logic [7:0] ref_rd(input logic [7:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return a ^ 8'h5A;
  endfunction

  initial begin
    m_left = 0; m_last = 1'b1; m_port = 1'b0; m_we = 1'b0;
    m_addr = '0; m_wdata = '0; m_result = '0; m_rdata0 = '0; m_rdata1 = '0;
    forever begin
      @(posedge clk_i or posedge rst_i);
      if (rst_i) begin
        m_left = 0; m_last = 1'b1; m_port = 1'b0; m_we = 1'b0;
        m_addr = '0; m_wdata = '0; m_rdata0 = '0; m_rdata1 = '0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 1 && !m_we) begin
          if (m_port) m_rdata1 = m_result;
          else        m_rdata0 = m_result;
        end
      end else if (req0_i || req1_i) begin
        m_port  = (req0_i && req1_i) ? !m_last : req1_i;
        m_last  = m_port;
        m_we    = m_port ? we1_i : we0_i;
        m_addr  = m_port ? addr1_i : addr0_i;
        m_wdata = m_port ? wdata1_i : wdata0_i;
        if (m_we) ref_mem[m_addr] = m_wdata;
        else      m_result = ref_rd(m_addr);
        m_left = 2;
      end
    end
  end

  int n_ack0 = 0, n_ack1 = 0, n_wen = 0, n_both = 0;
  bit order [$];
  logic [7:0] last_w_addr = '0, last_w_data = '0;

  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        chk("busy",      busy_o,      m_left != 0);
        chk("mem_r_en",  mem_r_en_o,  m_left == 2 && !m_we);
        chk("mem_w_en",  mem_w_en_o,  m_left == 2 && m_we);
        chk("ack0",      ack0_o,      m_left == 1 && !m_port);
        chk("ack1",      ack1_o,      m_left == 1 && m_port);
        chk("mem_addr",  mem_addr_o,  m_addr);
        chk("mem_wdata", mem_wdata_o, m_wdata);
        chk("rdata0",    rdata0_o,    m_rdata0);
        chk("rdata1",    rdata1_o,    m_rdata1);
      end
      if (ack0_o === 1'b1) begin n_ack0++; order.push_back(1'b0); end
      if (ack1_o === 1'b1) begin n_ack1++; order.push_back(1'b1); end
      if (ack0_o === 1'b1 && ack1_o === 1'b1) n_both++;
      if (mem_w_en_o === 1'b1) begin
        n_wen++; last_w_addr = mem_addr_o; last_w_data = mem_wdata_o;
      end
    end
  end

  // Issue one request from posedge+1, hold until its ack, drop on the next edge.
  task automatic xfer(input bit p, input bit we, input logic [7:0] a, input logic [7:0] d,
                      output int lat);
    if (p) begin req1_i = 1'b1; we1_i = we; addr1_i = a; wdata1_i = d; end
    else   begin req0_i = 1'b1; we0_i = we; addr0_i = a; wdata0_i = d; end
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk_i);
      if ((p ? ack1_o : ack0_o) === 1'b1) begin lat = n; break; end
    end
    chk("ack_seen", lat != 0, 1);
    @(posedge clk_i); #1;
    if (p) req1_i = 1'b0; else req0_i = 1'b0;
  endtask

  initial begin
    int lat, l0, l1, n, nw, found;
    rst_i = 1'b1;
    req0_i = 0; req1_i = 0; we0_i = 0; we1_i = 0;
    addr0_i = 0; addr1_i = 0; wdata0_i = 0; wdata1_i = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(posedge clk_i); #1;

    // T2: write then read back on port 0
    nw = n_wen;
    xfer(0, 1'b1, 8'h10, 8'hA5, lat);
    chk("t2_w_lat", lat, 3);
    chk("t2_wen_cycles", n_wen - nw, 1);
    chk("t2_w_addr", last_w_addr, 8'h10);
    chk("t2_w_data", last_w_data, 8'hA5);
    xfer(0, 1'b0, 8'h10, 8'h00, lat);
    chk("t2_r_lat", lat, 3);
    chk("t2_rdata0", rdata0_o, 8'hA5);
    chk("t2_rdata1", rdata1_o, 8'h00);
    chk("t2_addr_hold", mem_addr_o, 8'h10);

    // T1: reset while idle clears everything at once
    #2 rst_i = 1'b1;
    #1;
    chk("t1_ack0", ack0_o, 0);
    chk("t1_ack1", ack1_o, 0);
    chk("t1_ren", mem_r_en_o, 0);
    chk("t1_wen", mem_w_en_o, 0);
    chk("t1_rdata0", rdata0_o, 8'h00);
    chk("t1_rdata1", rdata1_o, 8'h00);
    chk("t1_busy", busy_o, 0);
    chk("t1_addr", mem_addr_o, 8'h00);
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(posedge clk_i); #1;

    // T3: both ports held high alternate 0,1,0,1
    order.delete();
    req0_i = 1; we0_i = 0; addr0_i = 8'h01;
    req1_i = 1; we1_i = 0; addr1_i = 8'h02;
    repeat (12) @(negedge clk_i);
    @(posedge clk_i); #1;
    req0_i = 0; req1_i = 0;
    chk("t3_count", order.size(), 4);
    if (order.size() == 4) begin
      chk("t3_g0", order[0], 0);
      chk("t3_g1", order[1], 1);
      chk("t3_g2", order[2], 0);
      chk("t3_g3", order[3], 1);
    end
    chk("t3_rdata0", rdata0_o, 8'h5B);
    chk("t3_rdata1", rdata1_o, 8'h58);
    chk("t3_no_overlap", n_both, 0);

    // T4: same-cycle read (port 0) and write (port 1) to one address
    xfer(1, 1'b1, 8'h00, 8'h3C, lat);
    fork
      xfer(0, 1'b0, 8'h00, 8'h00, l0);
      xfer(1, 1'b1, 8'h00, 8'hFF, l1);
    join
    chk("t4_l0", l0, 3);
    chk("t4_l1", l1, 6);
    chk("t4_rdata0", rdata0_o, 8'h3C);
    chk("t4_mem", mem[0], 8'hFF);
    xfer(1, 1'b0, 8'h00, 8'h00, lat);
    chk("t4_rdata1", rdata1_o, 8'hFF);

    // T5: reset during a port 1 write access
    req1_i = 1; we1_i = 1; addr1_i = 8'h20; wdata1_i = 8'h77;
    found = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      if (mem_w_en_o === 1'b1) begin found = 1; break; end
    end
    chk("t5_wen_seen", found, 1);
    n = n_ack1;
    #1 rst_i = 1'b1;
    #1;
    chk("t5_wen", mem_w_en_o, 0);
    chk("t5_ack1", ack1_o, 0);
    chk("t5_busy", busy_o, 0);
    req1_i = 0;
    @(posedge clk_i); #1 rst_i = 1'b0;
    repeat (2) @(posedge clk_i); #1;
    chk("t5_no_ack", n_ack1 - n, 0);
    xfer(1, 1'b0, 8'h20, 8'h00, lat);
    chk("t5_lat", lat, 3);
    chk("t5_rdata1", rdata1_o, 8'h77);

    // T6a: req0 dropped during ACCESS still gets one ack
    n = n_ack0;
    req0_i = 1; we0_i = 0; addr0_i = 8'h10;
    @(posedge clk_i); #1 req0_i = 0;
    repeat (5) @(negedge clk_i);
    chk("t6_one_ack", n_ack0 - n, 1);
    chk("t6_rdata0", rdata0_o, 8'hA5);
    @(posedge clk_i); #1;

    // T6b: req0 held past ack; we0 flipped during ACCESS only affects the next access
    xfer(0, 1'b1, 8'h30, 8'h11, lat);
    n = n_ack0;
    req0_i = 1; we0_i = 0; addr0_i = 8'h30; wdata0_i = 8'h99;
    @(posedge clk_i); #1 we0_i = 1;
    repeat (2) @(negedge clk_i);
    chk("t6_ack0_first", ack0_o, 1);
    chk("t6_read_kept", rdata0_o, 8'h11);
    repeat (3) @(negedge clk_i);
    chk("t6_two_acks", n_ack0 - n, 2);
    @(posedge clk_i); #1 req0_i = 0;
    chk("t6_second_write", mem[8'h30], 8'h99);
    repeat (4) @(posedge clk_i); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
